// File: rtl/cl_decode_pipe_pkg.sv
// Shared ISA definitions for the decode stage: instruction layout, control bundle,
// opcode encodings and the load-scoreboard entry type.
package cl_decode_pipe_pkg;

    localparam int ISA_OPCODE_W  = 6;
    localparam int ISA_RF_ADDR_W = 5;
    localparam int ISA_RS_IMM_W  = 5;
    // Scoreboard rd storage is wide enough for any supported register-address width.
    localparam int SB_RD_W       = 8;

    typedef struct packed {
        logic [ISA_OPCODE_W-1:0]  opcode;
        logic [ISA_RF_ADDR_W-1:0] rd;
        logic [ISA_RS_IMM_W-1:0]  rs_imm;
    } instruction_s;

    typedef struct packed {
        logic is_load_op_c;
        logic op_writes_rf_c;
        logic is_mem_op_c;
        logic is_store_op_c;
        logic is_byte_op_c;
        logic reads_rs_c;
        logic reads_rd_c;
    } ctrl_sigs;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
    } sb_entry_s;

    localparam int SB_ENTRY_W = $bits(sb_entry_s);

    localparam logic [ISA_OPCODE_W-1:0] OP_ADDU  = 6'h01;
    localparam logic [ISA_OPCODE_W-1:0] OP_SUBU  = 6'h02;
    localparam logic [ISA_OPCODE_W-1:0] OP_SLLV  = 6'h03;
    localparam logic [ISA_OPCODE_W-1:0] OP_SRAV  = 6'h04;
    localparam logic [ISA_OPCODE_W-1:0] OP_SRLV  = 6'h05;
    localparam logic [ISA_OPCODE_W-1:0] OP_AND   = 6'h06;
    localparam logic [ISA_OPCODE_W-1:0] OP_OR    = 6'h07;
    localparam logic [ISA_OPCODE_W-1:0] OP_NOR   = 6'h08;
    localparam logic [ISA_OPCODE_W-1:0] OP_SLT   = 6'h09;
    localparam logic [ISA_OPCODE_W-1:0] OP_SLTU  = 6'h0A;
    localparam logic [ISA_OPCODE_W-1:0] OP_MOV   = 6'h0B;
    localparam logic [ISA_OPCODE_W-1:0] OP_JALR  = 6'h0C;
    localparam logic [ISA_OPCODE_W-1:0] OP_LW    = 6'h0D;
    localparam logic [ISA_OPCODE_W-1:0] OP_LBU   = 6'h0E;
    localparam logic [ISA_OPCODE_W-1:0] OP_SW    = 6'h0F;
    localparam logic [ISA_OPCODE_W-1:0] OP_SB    = 6'h10;
    localparam logic [ISA_OPCODE_W-1:0] OP_SLCR  = 6'h11;
    localparam logic [ISA_OPCODE_W-1:0] OP_SRCR  = 6'h12;
    localparam logic [ISA_OPCODE_W-1:0] OP_MYXOR = 6'h13;

endpackage

// File: rtl/cl_decode_pipe_scoreboard.sv
// Load-destination scoreboard: a shift register of {valid, rd} slots that ages
// each in-flight load until its data can be forwarded.
module cl_load_scoreboard
    import cl_decode_pipe_pkg::*;
#(
    parameter int LOAD_LAT  = 2,
    parameter int RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 push_i,
    input  logic [RF_ADDR_W-1:0] push_rd_i,
    input  logic                 shift_i,
    input  logic [RF_ADDR_W-1:0] qry_rs_i,
    input  logic                 qry_rs_en_i,
    input  logic [RF_ADDR_W-1:0] qry_rd_i,
    input  logic                 qry_rd_en_i,
    output logic                 hit_o
);

    sb_entry_s [LOAD_LAT-1:0] slot_q;
    sb_entry_s [LOAD_LAT-1:0] slot_d;

    // Next-state: age slots on an advance, then a new load lands in slot 0.
    always_comb begin
        slot_d = slot_q;
        for (int i = 1; i < LOAD_LAT; i++) begin
            slot_d[i] = shift_i ? slot_q[i-1] : slot_q[i];
        end
        if (push_i) begin
            slot_d[0] = {1'b1, SB_RD_W'(push_rd_i)};
        end else if (shift_i) begin
            slot_d[0] = {SB_ENTRY_W{1'b0}};
        end else begin
            slot_d[0] = slot_q[0];
        end
    end

    // Slot storage.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            slot_q <= {(LOAD_LAT*SB_ENTRY_W){1'b0}};
        end else begin
            slot_q <= slot_d;
        end
    end

    // Match any live slot against the consumer's source registers.
    always_comb begin
        hit_o = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            hit_o = hit_o | (slot_q[i].valid &
                    ((qry_rs_en_i & (slot_q[i].rd == SB_RD_W'(qry_rs_i))) |
                     (qry_rd_en_i & (slot_q[i].rd == SB_RD_W'(qry_rd_i)))));
        end
    end

endmodule

// File: rtl/cl_decode_pipe.sv
// Registered decode stage between fetch and execute, with a load-use interlock
// that holds back consumers until the producing load can be forwarded.
module cl_decode_pipe
    import cl_decode_pipe_pkg::*;
#(
    parameter int INSTR_W     = 16,
    parameter int RF_ADDR_W   = 5,
    parameter int LOAD_LAT    = 2,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instruction_i,
    input  logic               flush_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instruction_o,
    output ctrl_sigs           ctrl_sigs_o,
    output logic               stall_o,
    output logic [15:0]        hazard_cnt_o
);

    // Field layout, LSB first: rs_imm, rd, opcode.
    logic [ISA_OPCODE_W-1:0] opcode_s;
    logic [RF_ADDR_W-1:0]    rd_s;
    logic [RF_ADDR_W-1:0]    rs_s;
    ctrl_sigs                ctrl_s;
    logic                    rs_en_s;
    logic                    rd_en_s;
    logic                    hit_s;
    logic                    hazard_s;
    logic                    stall_s;
    logic                    accept_s;

    logic                    out_valid_q, out_valid_d;
    logic [INSTR_W-1:0]      instr_q, instr_d;
    ctrl_sigs                ctrl_q, ctrl_d;
    logic [15:0]             cnt_q, cnt_d;

    assign opcode_s = instruction_i[2*RF_ADDR_W +: ISA_OPCODE_W];
    assign rd_s     = instruction_i[RF_ADDR_W +: RF_ADDR_W];
    assign rs_s     = instruction_i[0 +: RF_ADDR_W];

    // Opcode decode; anything unrecognised yields an inert all-zero bundle.
    always_comb begin
        ctrl_s = 7'b0000000;
        case (opcode_s)
            OP_ADDU, OP_SUBU, OP_SLLV, OP_SRAV, OP_SRLV, OP_AND, OP_OR,
            OP_NOR, OP_SLT, OP_SLTU, OP_SLCR, OP_SRCR, OP_MYXOR: begin
                ctrl_s.op_writes_rf_c = 1'b1;
                ctrl_s.reads_rs_c     = 1'b1;
                ctrl_s.reads_rd_c     = 1'b1;
            end
            OP_MOV, OP_JALR: begin
                ctrl_s.op_writes_rf_c = 1'b1;
                ctrl_s.reads_rs_c     = 1'b1;
            end
            OP_LW, OP_LBU: begin
                ctrl_s.is_load_op_c   = 1'b1;
                ctrl_s.op_writes_rf_c = 1'b1;
                ctrl_s.is_mem_op_c    = 1'b1;
                ctrl_s.is_byte_op_c   = (opcode_s == OP_LBU);
                ctrl_s.reads_rs_c     = 1'b1;
            end
            OP_SW, OP_SB: begin
                ctrl_s.is_mem_op_c    = 1'b1;
                ctrl_s.is_store_op_c  = 1'b1;
                ctrl_s.is_byte_op_c   = (opcode_s == OP_SB);
                ctrl_s.reads_rs_c     = 1'b1;
                ctrl_s.reads_rd_c     = 1'b1;
            end
            default: begin
                ctrl_s = 7'b0000000;
            end
        endcase
    end

    assign rs_en_s  = ctrl_s.reads_rs_c & ~(ZERO_REG_EN & (rs_s == {RF_ADDR_W{1'b0}}));
    assign rd_en_s  = ctrl_s.reads_rd_c & ~(ZERO_REG_EN & (rd_s == {RF_ADDR_W{1'b0}}));
    assign hazard_s = in_valid & hit_s;
    // A flush masks the hazard so flushed cycles are never counted as stalls.
    assign stall_s  = hazard_s & ~flush_i;
    assign in_ready = ~hazard_s & (~out_valid_q | out_ready) & ~flush_i;
    assign accept_s = in_valid & in_ready;

    cl_load_scoreboard #(
        .LOAD_LAT  (LOAD_LAT),
        .RF_ADDR_W (RF_ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .n_reset     (n_reset),
        .push_i      (accept_s & ctrl_s.is_load_op_c),
        .push_rd_i   (rd_s),
        .shift_i     (out_ready),
        .qry_rs_i    (rs_s),
        .qry_rs_en_i (rs_en_s),
        .qry_rd_i    (rd_s),
        .qry_rd_en_i (rd_en_s),
        .hit_o       (hit_s)
    );

    // Output-register next state: flush kills, accept loads, a drained slot becomes a bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        ctrl_d      = ctrl_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            instr_d     = instruction_i;
            ctrl_d      = ctrl_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        cnt_d = (stall_s && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
    end

    // Output bundle and stall counter registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            out_valid_q <= 1'b0;
            instr_q     <= {INSTR_W{1'b0}};
            ctrl_q      <= 7'b0000000;
            cnt_q       <= 16'h0000;
        end else begin
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            ctrl_q      <= ctrl_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign instruction_o = instr_q;
    assign ctrl_sigs_o   = ctrl_q;
    assign stall_o       = stall_s;
    assign hazard_cnt_o  = cnt_q;

endmodule

// File: tb/tb_cl_decode_pipe.sv
// Directed bench for cl_decode_pipe: a decode table plus hand-built sequences for
// the load-use interlock, backpressure, flush and reset corner cases.
module tb_cl_decode_pipe;
    import cl_decode_pipe_pkg::*;

    logic        clk;
    logic        n_reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instruction_i;
    logic        flush_i;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] instruction_o;
    ctrl_sigs    ctrl_sigs_o;
    logic        stall_o;
    logic [15:0] hazard_cnt_o;
    logic [6:0]  ctrl_bits;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [15:0] ins;
        logic [6:0]  ctrl;
    } vec_t;

    vec_t vecs [10];

    assign ctrl_bits = ctrl_sigs_o;

    cl_decode_pipe #(
        .INSTR_W     (16),
        .RF_ADDR_W   (5),
        .LOAD_LAT    (2),
        .ZERO_REG_EN (1'b1)
    ) dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instruction_i (instruction_i),
        .flush_i       (flush_i),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .instruction_o (instruction_o),
        .ctrl_sigs_o   (ctrl_sigs_o),
        .stall_o       (stall_o),
        .hazard_cnt_o  (hazard_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs);
        return {op, rd, rs};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one clock and settle 2ns past the rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cyc();
    endtask

    initial begin
        clk           = 1'b0;
        n_reset       = 1'b0;
        in_valid      = 1'b0;
        instruction_i = 16'h0000;
        flush_i       = 1'b0;
        out_ready     = 1'b1;
        n_cmp         = 0;
        n_bad         = 0;

        // ctrl bit order: load, writes_rf, mem, store, byte, reads_rs, reads_rd
        vecs[0] = '{mk(OP_ADDU,  5'd1,  5'd2),  7'b0100011};
        vecs[1] = '{mk(OP_MOV,   5'd3,  5'd4),  7'b0100010};
        vecs[2] = '{mk(OP_JALR,  5'd31, 5'd5),  7'b0100010};
        vecs[3] = '{mk(OP_LW,    5'd9,  5'd6),  7'b1110010};
        vecs[4] = '{mk(OP_LBU,   5'd10, 5'd7),  7'b1110110};
        vecs[5] = '{mk(OP_SW,    5'd11, 5'd8),  7'b0011011};
        vecs[6] = '{mk(OP_SB,    5'd12, 5'd13), 7'b0011111};
        vecs[7] = '{mk(OP_SLCR,  5'd14, 5'd15), 7'b0100011};
        vecs[8] = '{mk(OP_NOR,   5'd16, 5'd17), 7'b0100011};
        vecs[9] = '{mk(6'h3F,    5'd18, 5'd19), 7'b0000000};

        // Reset
        repeat (3) @(posedge clk);
        #2;
        n_reset = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_cnt", 32'(hazard_cnt_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_instr", 32'(instruction_o), 32'd0);
        chk("rst_ctrl", 32'(ctrl_bits), 32'd0);

        // Decode table
        for (int i = 0; i < 10; i++) begin
            in_valid      = 1'b1;
            instruction_i = vecs[i].ins;
            #1;
            chk("tbl_in_ready", 32'(in_ready), 32'd1);
            cyc();
            in_valid = 1'b0;
            chk("tbl_out_valid", 32'(out_valid), 32'd1);
            chk("tbl_instr", 32'(instruction_o), 32'(vecs[i].ins));
            chk("tbl_ctrl", 32'(ctrl_bits), 32'(vecs[i].ctrl));
            repeat (3) cyc();
        end

        // Pipelined ALU stream
        in_valid = 1'b1;
        instruction_i = mk(OP_ADDU, 5'd1, 5'd2);
        #1;
        chk("alu_stall0", 32'(stall_o), 32'd0);
        cyc();
        instruction_i = mk(OP_SUBU, 5'd3, 5'd1);
        #1;
        chk("alu_out1_valid", 32'(out_valid), 32'd1);
        chk("alu_out1_wr", 32'(ctrl_sigs_o.op_writes_rf_c), 32'd1);
        chk("alu_stall1", 32'(stall_o), 32'd0);
        chk("alu_in_ready1", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        chk("alu_out2_valid", 32'(out_valid), 32'd1);
        chk("alu_out2_instr", 32'(instruction_o), 32'(mk(OP_SUBU, 5'd3, 5'd1)));
        chk("alu_out2_wr", 32'(ctrl_sigs_o.op_writes_rf_c), 32'd1);
        idle(3);

        // Load-use: LW r4 then ADDU r5,r4
        in_valid = 1'b1;
        instruction_i = mk(OP_LW, 5'd4, 5'd2);
        cyc();
        instruction_i = mk(OP_ADDU, 5'd5, 5'd4);
        #1;
        chk("lu_c1_lw_out", 32'(instruction_o), 32'(mk(OP_LW, 5'd4, 5'd2)));
        chk("lu_c1_stall", 32'(stall_o), 32'd1);
        chk("lu_c1_in_ready", 32'(in_ready), 32'd0);
        cyc();
        chk("lu_c2_bubble", 32'(out_valid), 32'd0);
        chk("lu_c2_stall", 32'(stall_o), 32'd1);
        cyc();
        chk("lu_c3_bubble", 32'(out_valid), 32'd0);
        chk("lu_c3_stall", 32'(stall_o), 32'd0);
        chk("lu_c3_in_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        chk("lu_c4_valid", 32'(out_valid), 32'd1);
        chk("lu_c4_instr", 32'(instruction_o), 32'(mk(OP_ADDU, 5'd5, 5'd4)));
        chk("lu_cnt", 32'(hazard_cnt_o), 32'd2);
        idle(3);

        // Zero register never hazards
        in_valid = 1'b1;
        instruction_i = mk(OP_LW, 5'd0, 5'd2);
        cyc();
        instruction_i = mk(OP_MOV, 5'd1, 5'd0);
        #1;
        chk("zr_stall", 32'(stall_o), 32'd0);
        chk("zr_in_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        chk("zr_instr", 32'(instruction_o), 32'(mk(OP_MOV, 5'd1, 5'd0)));
        idle(3);

        // Backpressure plus hazard: LW r4 then SW r4
        in_valid = 1'b1;
        instruction_i = mk(OP_LW, 5'd4, 5'd3);
        cyc();
        instruction_i = mk(OP_SW, 5'd4, 5'd6);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_instr", 32'(instruction_o), 32'(mk(OP_LW, 5'd4, 5'd3)));
            chk("bp_hold_ctrl", 32'(ctrl_bits), 32'd114);
            chk("bp_hold_stall", 32'(stall_o), 32'd1);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_r1_stall", 32'(stall_o), 32'd1);
        cyc();
        chk("bp_r2_bubble", 32'(out_valid), 32'd0);
        chk("bp_r2_stall", 32'(stall_o), 32'd1);
        cyc();
        chk("bp_r3_stall", 32'(stall_o), 32'd0);
        chk("bp_r3_in_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        chk("bp_sw_valid", 32'(out_valid), 32'd1);
        chk("bp_sw_instr", 32'(instruction_o), 32'(mk(OP_SW, 5'd4, 5'd6)));
        chk("bp_cnt", 32'(hazard_cnt_o), 32'd9);
        idle(3);

        // Flush mid-stall
        in_valid = 1'b1;
        instruction_i = mk(OP_LW, 5'd7, 5'd1);
        cyc();
        instruction_i = mk(OP_ADDU, 5'd2, 5'd7);
        #1;
        chk("fl_pre_stall", 32'(stall_o), 32'd1);
        flush_i   = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("fl_stall", 32'(stall_o), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd0);
        cyc();
        flush_i   = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("fl_killed", 32'(out_valid), 32'd0);
        chk("fl_restall1", 32'(stall_o), 32'd1);
        cyc();
        chk("fl_restall2", 32'(stall_o), 32'd1);
        cyc();
        chk("fl_release", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        chk("fl_out_valid", 32'(out_valid), 32'd1);
        chk("fl_out_instr", 32'(instruction_o), 32'(mk(OP_ADDU, 5'd2, 5'd7)));
        chk("fl_cnt", 32'(hazard_cnt_o), 32'd11);
        idle(3);

        // Reset asserted mid-stall
        in_valid = 1'b1;
        instruction_i = mk(OP_LW, 5'd4, 5'd2);
        cyc();
        instruction_i = mk(OP_ADDU, 5'd5, 5'd4);
        #1;
        chk("rs_pre_stall", 32'(stall_o), 32'd1);
        n_reset = 1'b0;
        #1;
        chk("rs_out_valid", 32'(out_valid), 32'd0);
        chk("rs_cnt", 32'(hazard_cnt_o), 32'd0);
        chk("rs_stall", 32'(stall_o), 32'd0);
        cyc();
        cyc();
        n_reset = 1'b1;
        #1;
        chk("rs_post_stall", 32'(stall_o), 32'd0);
        chk("rs_post_in_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        chk("rs_post_valid", 32'(out_valid), 32'd1);
        chk("rs_post_instr", 32'(instruction_o), 32'(mk(OP_ADDU, 5'd5, 5'd4)));
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
